// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [XLEN-1:0] NOP_RV       = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
    logic            dvalid;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_resp_fifo.sv
// 2-entry response queue with flush and a late data-capture write port.
module fetch_resp_fifo import fetch_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  fetch_entry_t      push_entry,
  input  logic              pop,
  input  logic              cap_we,
  input  logic              cap_slot,
  input  logic [XLEN-1:0]   cap_instr,
  output fetch_entry_t      head_entry,
  output logic              head_ptr,
  output logic              tail_ptr,
  output logic [1:0]        count
);
  fetch_entry_t [1:0] mem_q, mem_d;
  logic               head_q, head_d, tail_q, tail_d;
  logic [1:0]         count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (cap_we) begin
      mem_d[cap_slot].instr  = cap_instr;
      mem_d[cap_slot].dvalid = 1'b1;
    end
    // a capture never targets the slot being pushed, so ordering is moot
    if (push) mem_d[tail_q] = push_entry;
  end

  always_comb begin
    head_d  = head_q ^ pop;
    tail_d  = tail_q ^ push;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_entry = mem_q[head_q];
  assign head_ptr   = head_q;
  assign tail_ptr   = tail_q;
  assign count      = count_q;
endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: address decode/fault check, ROM drive, response queue
// and a bypass of ROM data for the entry issued on the previous cycle.
module imem_fetch_responder import fetch_pkg::*; #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = RESET_VECTOR,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = NOP_RV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [DATA_WIDTH-1:0] rsp_pc,
  output logic [DATA_WIDTH-1:0] rsp_pcplus4,
  output logic                  rsp_fault
);
  logic [DATA_WIDTH-3:0] word_off;
  logic                  fault, accept, pop, head_bypass;
  logic                  pend_q, pend_d, pend_slot_q, pend_slot_d;
  logic                  head_ptr, tail_ptr;
  logic [1:0]            count;
  fetch_entry_t          push_entry, head_entry;

  // BASE_ADDR is word aligned, so the offset is taken in words directly
  assign word_off = req_addr[DATA_WIDTH-1:2] - BASE_ADDR[DATA_WIDTH-1:2];
  assign fault    = (req_addr[1:0] != 2'b00) ||
                    (word_off[DATA_WIDTH-3:ADDR_WIDTH] != '0);

  assign pop       = rsp_valid && rsp_ready;
  assign req_ready = ((count < 2'd2) || pop) && !flush;
  assign accept    = req_valid && req_ready;
  assign rom_addr  = accept ? word_off[ADDR_WIDTH-1:0] : '0;

  always_comb begin
    push_entry        = '0;
    push_entry.pc     = req_addr;
    push_entry.fault  = fault;
    push_entry.dvalid = fault;
    push_entry.instr  = fault ? NOP_INSTR : '0;
  end

  // accept is impossible during flush, so pend_d also clears on flush
  always_comb begin
    pend_d      = accept && !fault;
    pend_slot_d = pend_d ? tail_ptr : pend_slot_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q      <= 1'b0;
      pend_slot_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
    end
  end

  fetch_resp_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .cap_we     (pend_q && !flush),
    .cap_slot   (pend_slot_q),
    .cap_instr  (rom_rdata),
    .head_entry (head_entry),
    .head_ptr   (head_ptr),
    .tail_ptr   (tail_ptr),
    .count      (count)
  );

  assign head_bypass = pend_q && (pend_slot_q == head_ptr);
  assign rsp_valid   = (count != 2'd0) && (head_entry.dvalid || head_bypass);

  always_comb begin
    rsp_instr   = '0;
    rsp_pc      = '0;
    rsp_pcplus4 = '0;
    rsp_fault   = 1'b0;
    if (rsp_valid) begin
      rsp_instr   = head_entry.dvalid ? head_entry.instr : rom_rdata;
      rsp_pc      = head_entry.pc;
      rsp_pcplus4 = head_entry.pc + 32'd4;
      rsp_fault   = head_entry.fault;
    end
  end
endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Instruction-fetch responder for the pipelined core: the memory-side end of the fetch interface driven by the PC stage. It accepts fetch addresses with a valid/ready handshake, reads a 1-cycle synchronous instruction ROM, and returns instruction, PC and PC+4 to the IF/ID register through a 2-entry response queue. The queue absorbs decode stalls. A redirect flush from Execute squashes all outstanding fetches.

## Interface

Parameters:
- DATA_WIDTH, 32, instruction/address width
- ADDR_WIDTH, 10, ROM word-index width (ROM depth = 2^ADDR_WIDTH words)
- BASE_ADDR, 32'hBFC00000, byte address of ROM word 0 (reset vector)
- NOP_INSTR, 32'h00000013, instruction returned on faulted fetch

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  PC stage presents a fetch address
- req_ready  out  1  responder can accept a fetch this cycle
- req_addr  in  DATA_WIDTH  fetch byte address (PCF)
- flush  in  1  redirect (taken branch/JALR in Execute); squash everything outstanding
- rom_addr  out  ADDR_WIDTH  ROM word index, registered by ROM at this edge
- rom_rdata  in  DATA_WIDTH  ROM data, valid the cycle after rom_addr sampled
- rsp_valid  out  1  head response valid
- rsp_ready  in  1  IF/ID register accepts response
- rsp_instr  out  DATA_WIDTH  fetched instruction
- rsp_pc  out  DATA_WIDTH  address of that instruction
- rsp_pcplus4  out  DATA_WIDTH  rsp_pc + 4, modulo 2^32
- rsp_fault  out  1  misaligned or out-of-range fetch

## Operation

- Accept = req_valid & req_ready. On accept:
  - push an entry {pc, fault, instr, dvalid=0} at the tail
  - drive rom_addr = (req_addr − BASE_ADDR)[ADDR_WIDTH+1:2]
- Fault is set when req_addr[1:0] ≠ 0, or when req_addr − BASE_ADDR (unsigned, 32-bit wrap) ≥ 4·2^ADDR_WIDTH.
  - Faulted entries are created with dvalid=1 and instr=NOP_INSTR.
  - rom_addr still drives the computed index and is ignored.
- Data capture: in the cycle after a non-faulted accept, rom_rdata is written into that entry and dvalid is set at the edge.
  - While the entry is head and not yet captured, rsp_instr muxes rom_rdata directly (bypass), so there is no bubble.
- rsp_valid = queue non-empty and (head.dvalid or head is the entry issued last cycle).
- Pop = rsp_valid & rsp_ready.
- req_ready = (count < 2) or pop this cycle, and !flush. Push and pop may occur in the same cycle when count=2.
- flush, at the next edge:
  - clears the queue and the pending-capture flag
  - rom_rdata arriving after the flush is discarded
  - flush forces req_ready=0 in its own cycle
  - pop during flush is permitted: the consumer may take the head that cycle, and the consumer is responsible for killing it
- State: count (0..2), head/tail pointers (1 bit each), pending-capture flag plus its slot pointer.

## Timing

- Latency: accept at edge N → rsp_valid during cycle N+1 (1 cycle); throughput 1 fetch/cycle when rsp_ready=1.
- Backpressure: with rsp_ready=0, at most 2 fetches are outstanding; the third is refused (req_ready=0).
- Outputs are held stable while rsp_valid=1 and rsp_ready=0.
- Reset (async assert, sync-released by the system):
  - queue empty, pending flag 0
  - rsp_valid=0, rsp_instr/rsp_pc/rsp_pcplus4=0, rsp_fault=0
  - rom_addr=0, req_ready=1
- Reset mid-operation discards all entries immediately; there is no response for in-flight fetches.
- Wrap-around: pointers toggle modulo 2; rsp_pcplus4 for 32'hFFFFFFFC is 32'h00000000 (and that access faults).

## Structure

- Package fetch_pkg: fetch_entry_t struct {pc, instr, fault, dvalid}, RESET_VECTOR/BASE_ADDR and NOP_INSTR constants.
- One sub-module: fetch_resp_fifo, a 2-entry FIFO of fetch_entry_t with a flush port and a data-capture write port.
- Top-level logic covers address decode, fault check, ROM drive and bypass mux.

## Test plan

- Stream: req_valid=1 with addresses 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles, rsp_ready=1. Required: rsp_valid on cycles 1–3 with ROM words 0–2, rsp_pcplus4 = pc+4.
- Backpressure: rsp_ready=0 with 3 requests. Required: first two accepted, req_ready=0 for the third; raising rsp_ready drains in order with unchanged data.
- Flush: 2 entries queued, plus one capture pending; pulse flush. Required: next cycle rsp_valid=0 and count 0; the late rom_rdata is never presented.
- Fault:
  - req_addr=0xBFC00002 → rsp_fault=1, rsp_instr=0x00000013
  - req_addr=BASE+4·2^ADDR_WIDTH → rsp_fault=1
- Reset mid-op: drop reset with 2 entries queued. Required: rsp_valid=0 and req_ready=1 immediately, all rsp_* = 0.
- Full with simultaneous push/pop: count=2 and rsp_ready=1 with req_valid=1. Required: accepted in the same cycle, and order is preserved.
